pipelined_cla_adder: RTL and testbench



---
 rtl/pipelined_cla_adder.sv | 132 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor: one BLOCK-bit lookahead group
// per stage, with operand skew and sum de-skew so every group of a beat emerges together.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NUM_BLK = WIDTH / BLOCK;

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  assign b_eff    = b ^ {WIDTH{sub}};
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Every carry is an independent OR of AND-terms over p/g/ci, so no ripple path exists.
  function automatic logic [BLOCK:0] lookahead(input logic [BLOCK-1:0] p,
                                               input logic [BLOCK-1:0] g,
                                               input logic             ci);
    logic [BLOCK:0] c;
    logic           term;
    c    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      term = ci;
      for (int unsigned m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = term;
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  for (genvar k = 0; k < NUM_BLK; k++) begin : stg
    logic [BLOCK-1:0]         ga, gb, gs;
    logic                     gc, gv;
    logic [BLOCK:0]           c;
    logic                     v_q, c_q;
    logic [(k+1)*BLOCK-1:0]   s_q, s_next;

    if (k == 0) begin : head
      assign ga     = a[BLOCK-1:0];
      assign gb     = b_eff[BLOCK-1:0];
      assign gc     = cin ^ sub;
      assign gv     = in_valid;
      assign s_next = gs;
    end else begin : body
      assign ga     = stg[k-1].skew.a_q[BLOCK-1:0];
      assign gb     = stg[k-1].skew.b_q[BLOCK-1:0];
      assign gc     = stg[k-1].c_q;
      assign gv     = stg[k-1].v_q;
      assign s_next = {gs, stg[k-1].s_q};
    end

    assign c  = lookahead(ga ^ gb, ga & gb, gc);
    assign gs = ga ^ gb ^ c[BLOCK-1:0];

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= gv;
        c_q <= c[BLOCK];
        s_q <= s_next;
      end
    end

    if (k < NUM_BLK - 1) begin : skew
      // Only the not-yet-consumed upper operand groups travel down the pipe.
      localparam int unsigned RW = WIDTH - (k + 1) * BLOCK;
      logic [RW-1:0] a_d, b_d, a_q, b_q;

      if (k == 0) begin : src_in
        assign a_d = a[WIDTH-1:BLOCK];
        assign b_d = b_eff[WIDTH-1:BLOCK];
      end else begin : src_stg
        assign a_d = stg[k-1].skew.a_q[RW+BLOCK-1:BLOCK];
        assign b_d = stg[k-1].skew.b_q[RW+BLOCK-1:BLOCK];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : tail
      logic ovf_q, zero_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance) begin
          ovf_q  <= c[BLOCK] ^ c[BLOCK-1];
          zero_q <= ~|s_next;
        end
      end
    end
  end

  assign out_valid = stg[NUM_BLK-1].v_q;
  assign sum       = stg[NUM_BLK-1].s_q;
  assign cout      = stg[NUM_BLK-1].c_q;
  assign ovf       = stg[NUM_BLK-1].tail.ovf_q;
  assign zero      = stg[NUM_BLK-1].tail.zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors on the 16/4 build, plus a random
// handshake regression on 16/4, 32/8 and 8/8 builds against a golden wide-add model.
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin, sub;
  logic [31:0] a32, b32;
  logic        rnd_on = 1'b0;

  int checks = 0;
  int errors = 0;

  logic        rdy16, ov16, co16, ovf16, z16;
  logic [15:0] sum16;
  logic        rdy32, ov32, co32, ovf32, z32;
  logic [31:0] sum32;
  logic        rdy8, ov8, co8, ovf8, z8;
  logic [7:0]  sum8;

  logic [63:0] q16[$];
  logic [63:0] q32[$];
  logic [63:0] q8[$];

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
    .a(a32[15:0]), .b(b32[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov16), .out_ready(out_ready), .sum(sum16),
    .cout(co16), .ovf(ovf16), .zero(z16)
  );

  pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .a(a32), .b(b32), .cin(cin), .sub(sub),
    .out_valid(ov32), .out_ready(out_ready), .sum(sum32),
    .cout(co32), .ovf(ovf32), .zero(z32)
  );

  pipelined_cla_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .a(a32[7:0]), .b(b32[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov8), .out_ready(out_ready), .sum(sum8),
    .cout(co8), .ovf(ovf8), .zero(z8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Golden result packed as {ovf, zero, cout, sum[31:0]} for a w-bit adder.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic s, input int unsigned w);
    logic [63:0] mask, xa, yb, t;
    logic        co, ov, z;
    mask = (64'd1 << w) - 64'd1;
    xa   = {32'd0, x} & mask;
    yb   = ({32'd0, y} ^ (s ? mask : 64'd0)) & mask;
    t    = xa + yb + {63'd0, ci ^ s};
    co   = t[w];
    ov   = (xa[w-1] == yb[w-1]) && (t[w-1] != xa[w-1]);
    z    = (t & mask) == 64'd0;
    t    = t & mask;
    return {29'd0, ov, z, co, t[31:0]};
  endfunction

  always @(negedge clk) begin
    if (rnd_on) begin
      if (in_valid && rdy16) q16.push_back(model(a32, b32, cin, sub, 16));
      if (ov16 && out_ready) begin
        if (q16.size() == 0) check("spurious16", {63'd0, ov16}, 64'd0);
        else check("rnd16", {29'd0, ovf16, z16, co16, 16'd0, sum16}, q16.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rnd_on) begin
      if (in_valid && rdy32) q32.push_back(model(a32, b32, cin, sub, 32));
      if (ov32 && out_ready) begin
        if (q32.size() == 0) check("spurious32", {63'd0, ov32}, 64'd0);
        else check("rnd32", {29'd0, ovf32, z32, co32, sum32}, q32.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rnd_on) begin
      if (in_valid && rdy8) q8.push_back(model(a32, b32, cin, sub, 8));
      if (ov8 && out_ready) begin
        if (q8.size() == 0) check("spurious8", {63'd0, ov8}, 64'd0);
        else check("rnd8", {29'd0, ovf8, z8, co8, 24'd0, sum8}, q8.pop_front());
      end
    end
  end

  // One beat into an empty 16/4 pipe; result must appear exactly 4 edges after acceptance.
  task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vcin, input logic vsub, input logic [15:0] esum,
                         input logic ecout, input logic eovf, input logic ezero);
    a32       = {16'd0, va};
    b32       = {16'd0, vb};
    cin       = vcin;
    sub       = vsub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check({tag, "_early"}, {63'd0, ov16}, 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {63'd0, ov16}, 64'd1);
    check({tag, "_sum"},   {48'd0, sum16}, {48'd0, esum});
    check({tag, "_cout"},  {63'd0, co16},  {63'd0, ecout});
    check({tag, "_ovf"},   {63'd0, ovf16}, {63'd0, eovf});
    check({tag, "_zero"},  {63'd0, z16},   {63'd0, ezero});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a32 = '0; b32 = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", {63'd0, ov16}, 64'd0);
    check("rst_sum",   {48'd0, sum16}, 64'd0);
    check("rst_flags", {61'd0, co16, ovf16, z16}, 64'd0);
    check("rst_ready", {61'd0, rdy16, rdy32, rdy8}, 64'd7);

    run_vec("uwrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_vec("sovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_vec("negovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    run_vec("borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_vec("subcin",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    run_vec("addcin",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
    run_vec("subovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_vec("grpcarry",16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

    // Backpressure: three beats, then stall the sink as the first result lands.
    sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a32 = i; b32 = i; in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", {63'd0, ov16}, 64'd1);
      check("stall_ready", {63'd0, rdy16}, 64'd0);
      check("stall_sum",   {48'd0, sum16}, 64'h2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_beat2", {47'd0, ov16, sum16}, {47'd0, 1'b1, 16'h0004});
    @(posedge clk);
    #1 check("bp_beat3", {47'd0, ov16, sum16}, {47'd0, 1'b1, 16'h0006});
    @(posedge clk);
    #1 check("bp_empty", {63'd0, ov16}, 64'd0);

    // Reset mid-flight: three beats in the pipe, then a one-cycle reset.
    for (int i = 0; i < 3; i++) begin
      a32 = 32'h1111 * (i + 1); b32 = 32'h1; in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mrst_valid", {63'd0, ov16}, 64'd0);
    check("mrst_out",   {45'd0, co16, ovf16, z16, sum16}, 64'd0);
    check("mrst_ready", {63'd0, rdy16}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check("mrst_ghost", {63'd0, ov16}, 64'd0);
    end

    // Random regression on all three builds.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rnd_on = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      a32       = $urandom;
      b32       = $urandom;
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("drain16", 64'(q16.size()), 64'd0);
    check("drain32", 64'(q32.size()), 64'd0);
    check("drain8",  64'(q8.size()),  64'd0);
    rnd_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
